// File: rtl/lib_pkg.sv
// Shared NetEmulation library package: width helpers and the per-channel status record.
package lib_pkg;

    // Wide enough for any practical per-channel depth; users slice the low bits they need.
    localparam int STATUS_CNT_W = 16;

    typedef struct packed {
        logic                    empty;
        logic                    full;
        logic                    almost_full;
        logic [STATUS_CNT_W-1:0] count;
    } chan_status_t;

    function automatic int vc_width(input int n_vc);
        return (n_vc > 1) ? $clog2(n_vc) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lib_vc_fifo_chan.sv
// One virtual channel: FWFT storage, wrapping pointers, explicit occupancy count and flush.
module lib_vc_fifo_chan
    import lib_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = DEPTH - 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_req,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output chan_status_t     status,
    output logic             wr_drop,
    output logic             pop_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic empty;
    logic full;
    logic do_pop;
    logic wr_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop on a full channel frees the slot the same cycle; flush swallows the write silently.
    assign wr_ok   = wr_req && (!full || pop) && !flush;
    assign wr_drop = wr_req && !flush && full && !pop;
    assign pop_err = pop && empty;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_ok, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_data;
    end

    assign head = empty ? '0 : mem[rd_ptr];

    always_comb begin
        status             = '0;
        status.empty       = empty;
        status.full        = full;
        status.almost_full = (count >= CNT_W'(AF_THRESH));
        status.count       = STATUS_CNT_W'(count);
    end

endmodule

// File: rtl/lib_vc_fifo.sv
// Multi-channel FWFT FIFO: one shared write port steered by channel index, independent per-channel reads.
module lib_vc_fifo
    import lib_pkg::*;
#(
    parameter  int WIDTH     = 4,
    parameter  int DEPTH     = 4,
    parameter  int N_VC      = 2,
    parameter  int AF_THRESH = DEPTH - 1,
    localparam int VC_W      = vc_width(N_VC),
    localparam int CNT_W     = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      i_data,
    input  logic                  i_data_val,
    input  logic [VC_W-1:0]       i_data_vc,
    input  logic [N_VC-1:0]       i_en,
    input  logic [N_VC-1:0]       i_flush,
    output logic [N_VC*WIDTH-1:0] o_data,
    output logic [N_VC-1:0]       o_data_val,
    output logic [N_VC-1:0]       o_en,
    output logic [N_VC-1:0]       o_empty,
    output logic [N_VC-1:0]       o_full,
    output logic [N_VC-1:0]       o_almost_full,
    output logic [N_VC*CNT_W-1:0] o_count,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    logic         vc_ok;
    logic [N_VC-1:0] wr_drop;
    logic [N_VC-1:0] pop_err;
    chan_status_t status [N_VC];

    assign vc_ok = (int'(i_data_vc) < N_VC);

    for (genvar v = 0; v < N_VC; v++) begin : g_chan
        logic wr_req;
        assign wr_req = i_data_val && vc_ok && (int'(i_data_vc) == v);

        lib_vc_fifo_chan #(
            .WIDTH     (WIDTH),
            .DEPTH     (DEPTH),
            .AF_THRESH (AF_THRESH)
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .wr_req  (wr_req),
            .wr_data (i_data),
            .pop     (i_en[v]),
            .flush   (i_flush[v]),
            .head    (o_data[v*WIDTH +: WIDTH]),
            .status  (status[v]),
            .wr_drop (wr_drop[v]),
            .pop_err (pop_err[v])
        );

        assign o_empty[v]                 = status[v].empty;
        assign o_data_val[v]              = !status[v].empty;
        assign o_full[v]                  = status[v].full;
        assign o_almost_full[v]           = status[v].almost_full;
        assign o_count[v*CNT_W +: CNT_W]  = status[v].count[CNT_W-1:0];
        // Combinational from i_en: a pop frees a full channel within the same cycle.
        assign o_en[v]                    = !status[v].full || i_en[v];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if ((|wr_drop) || (i_data_val && !vc_ok))
                o_overflow <= 1'b1;
            if (|pop_err)
                o_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lib_vc_fifo.sv
// Scoreboard bench for lib_vc_fifo: queue-per-channel reference model checked every cycle.
module tb_lib_vc_fifo;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int N_VC  = 2;
    localparam int AF    = 3;
    localparam int VC_W  = 1;
    localparam int CNT_W = 3;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [WIDTH-1:0]      i_data;
    logic                  i_data_val;
    logic [VC_W-1:0]       i_data_vc;
    logic [N_VC-1:0]       i_en;
    logic [N_VC-1:0]       i_flush;
    logic [N_VC*WIDTH-1:0] o_data;
    logic [N_VC-1:0]       o_data_val;
    logic [N_VC-1:0]       o_en;
    logic [N_VC-1:0]       o_empty;
    logic [N_VC-1:0]       o_full;
    logic [N_VC-1:0]       o_almost_full;
    logic [N_VC*CNT_W-1:0] o_count;
    logic                  o_overflow;
    logic                  o_underflow;

    lib_vc_fifo #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .N_VC      (N_VC),
        .AF_THRESH (AF)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_data        (i_data),
        .i_data_val    (i_data_val),
        .i_data_vc     (i_data_vc),
        .i_en          (i_en),
        .i_flush       (i_flush),
        .o_data        (o_data),
        .o_data_val    (o_data_val),
        .o_en          (o_en),
        .o_empty       (o_empty),
        .o_full        (o_full),
        .o_almost_full (o_almost_full),
        .o_count       (o_count),
        .o_overflow    (o_overflow),
        .o_underflow   (o_underflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one queue of expected words per channel plus the two sticky flags.
    int q [N_VC][$];
    bit ovf = 1'b0;
    bit unf = 1'b0;
    bit model_ok = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare DUT state with the model, then apply this cycle's inputs to the model.
    always @(negedge clk) begin
        int  sz;
        bit  wr;
        bit  can_wr;
        if (model_ok) begin
            for (int v = 0; v < N_VC; v++) begin
                sz = q[v].size();
                chk($sformatf("count[%0d]", v), 32'(o_count[v*CNT_W +: CNT_W]), 32'(sz));
                chk($sformatf("empty[%0d]", v), 32'(o_empty[v]), 32'(sz == 0));
                chk($sformatf("data_val[%0d]", v), 32'(o_data_val[v]), 32'(sz != 0));
                chk($sformatf("full[%0d]", v), 32'(o_full[v]), 32'(sz == DEPTH));
                chk($sformatf("almost_full[%0d]", v), 32'(o_almost_full[v]), 32'(sz >= AF));
                chk($sformatf("head[%0d]", v), 32'(o_data[v*WIDTH +: WIDTH]),
                    (sz != 0) ? 32'(q[v][0]) : 32'd0);
                chk($sformatf("en[%0d]", v), 32'(o_en[v]), 32'((sz < DEPTH) || i_en[v]));
            end
            chk("overflow", 32'(o_overflow), 32'(ovf));
            chk("underflow", 32'(o_underflow), 32'(unf));
        end

        if (!reset_n) begin
            for (int v = 0; v < N_VC; v++) q[v].delete();
            ovf      = 1'b0;
            unf      = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            for (int v = 0; v < N_VC; v++) begin
                sz     = q[v].size();
                wr     = i_data_val && (int'(i_data_vc) == v);
                can_wr = (sz < DEPTH) || i_en[v];
                if (i_en[v] && sz == 0)
                    unf = 1'b1;
                if (i_flush[v]) begin
                    q[v].delete();
                end else begin
                    if (wr && !can_wr)
                        ovf = 1'b1;
                    if (i_en[v] && sz > 0)
                        void'(q[v].pop_front());
                    if (wr && can_wr)
                        q[v].push_back(int'(i_data));
                end
            end
        end
    end

    task automatic cyc(input bit rn, input bit dv, input bit vc, input logic [WIDTH-1:0] d,
                       input logic [N_VC-1:0] en, input logic [N_VC-1:0] fl);
        reset_n    = rn;
        i_data_val = dv;
        i_data_vc  = vc;
        i_data     = d;
        i_en       = en;
        i_flush    = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        cyc(0, 0, 0, 4'h0, 2'b00, 2'b00);
        cyc(0, 0, 0, 4'h0, 2'b00, 2'b00);
        cyc(1, 0, 0, 4'h0, 2'b00, 2'b00);
        // Fill VC0 with D,E,A,D
        cyc(1, 1, 0, 4'hD, 2'b00, 2'b00);
        cyc(1, 1, 0, 4'hE, 2'b00, 2'b00);
        cyc(1, 1, 0, 4'hA, 2'b00, 2'b00);
        cyc(1, 1, 0, 4'hD, 2'b00, 2'b00);
        cyc(1, 0, 0, 4'h0, 2'b00, 2'b00);
        // Write to full VC0 without pop: dropped
        cyc(1, 1, 0, 4'hB, 2'b00, 2'b00);
        cyc(1, 0, 0, 4'h0, 2'b00, 2'b00);
        // Write to full VC0 with pop, then drain
        cyc(1, 1, 0, 4'hB, 2'b01, 2'b00);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 4'h0, 2'b01, 2'b00);
        cyc(1, 0, 0, 4'h0, 2'b00, 2'b00);
        // Interleave VC1 writes of 1 and VC0 writes of 7 while popping VC0
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) cyc(1, 1, 1, 4'h1, 2'b01, 2'b00);
            else            cyc(1, 1, 0, 4'h7, 2'b01, 2'b00);
        end
        // Drain VC1 then pop-while-writing on empty VC1
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 4'h0, 2'b10, 2'b00);
        cyc(1, 1, 1, 4'h5, 2'b10, 2'b00);
        cyc(1, 0, 0, 4'h0, 2'b00, 2'b00);
        // Three words in VC0, flush with a same-cycle write, then mid-stream reset
        cyc(1, 0, 0, 4'h0, 2'b01, 2'b00);
        cyc(1, 1, 0, 4'h3, 2'b00, 2'b00);
        cyc(1, 1, 0, 4'h6, 2'b00, 2'b00);
        cyc(1, 1, 0, 4'h9, 2'b00, 2'b00);
        cyc(1, 1, 0, 4'hC, 2'b00, 2'b01);
        cyc(1, 1, 1, 4'h2, 2'b00, 2'b00);
        cyc(0, 1, 0, 4'h4, 2'b01, 2'b00);
        cyc(1, 0, 0, 4'h0, 2'b00, 2'b00);
        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 99) != 0),
                ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)),
                4'($urandom),
                {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)},
                {($urandom_range(0, 39) == 0), ($urandom_range(0, 39) == 0)});
        end
        cyc(1, 0, 0, 4'h0, 2'b00, 2'b00);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lib_vc_fifo.md
Name: lib_vc_fifo

Overview:
Multi-channel (virtual-channel) first-word-fall-through FIFO for the NetEmulation library, generalising the single-channel library FIFO.
- One shared write port steers each word into one of N_VC independent queues by channel index.
- Each channel has its own head output, read enable, status flags and occupancy count.
- Adds almost-full, per-channel flush and sticky overflow/underflow error flags.
- Sits between router input ports and the VC allocator/switch.

Parameters:
WIDTH, 4, data word width in bits (>=1)
DEPTH, 4, entries per channel; power of two, >=2
N_VC, 2, number of channels (>=1)
AF_THRESH, DEPTH-1, o_almost_full[v] asserts when count[v] >= AF_THRESH (1..DEPTH)

Ports:
clk  in  1  single clock, all logic on rising edge
reset_n  in  1  reset, synchronous, active-low
i_data  in  WIDTH  write data
i_data_val  in  1  write request
i_data_vc  in  VC_W  target channel; VC_W = max(1, clog2(N_VC))
i_en  in  N_VC  per-channel read/pop: head of channel v consumed this cycle
i_flush  in  N_VC  per-channel synchronous flush
o_data  out  N_VC*WIDTH  head word of each channel (channel v at bits v*WIDTH +: WIDTH)
o_data_val  out  N_VC  head valid (= !o_empty)
o_en  out  N_VC  channel can accept a write this cycle: !o_full[v] || i_en[v]
o_empty  out  N_VC  count[v]==0
o_full  out  N_VC  count[v]==DEPTH
o_almost_full  out  N_VC  count[v] >= AF_THRESH
o_count  out  N_VC*CNT_W  occupancy; CNT_W = clog2(DEPTH+1)
o_overflow  out  1  sticky: a write was dropped
o_underflow  out  1  sticky: pop requested on an empty channel

Behaviour:
- Reset (reset_n=0 at an edge):
  - all pointers and counts 0; o_empty all 1; o_full, o_almost_full, o_data_val, o_overflow, o_underflow all 0.
  - o_data is 0 for every empty channel; storage is not reset.
  - Reset mid-operation discards all contents and has priority over every other input.
- FWFT read path:
  - o_data[v] = mem[v][rd_ptr[v]] when non-empty, else 0.
  - Purely from registers; no combinational path from i_en to o_data.
- Write latency: a word accepted at edge k is on o_data[v] after edge k if the channel was empty. Empty-to-valid latency is 1 cycle.
- Pop: i_en[v] && !o_empty[v] advances rd_ptr[v] at the edge. i_en[v] on an empty channel is ignored and sets o_underflow.
- Write acceptance: i_data_val && (count[w] < DEPTH || i_en[w]) where w = i_data_vc.
  - A write to a full channel succeeds only when that channel pops in the same cycle; count stays DEPTH.
  - A rejected write, or one with i_data_vc >= N_VC, is dropped and sets o_overflow.
- Simultaneous write and pop on the same non-empty channel: count unchanged, both pointers advance.
- Write to an empty channel with i_en set the same cycle: the pop is ignored (o_underflow set), the write is accepted, count becomes 1.
- Writes and pops on different channels are fully independent.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Count is tracked explicitly, with no extra-MSB trick.
- Flush: i_flush[v] zeroes rd_ptr, wr_ptr and count of channel v at the edge.
  - It overrides a same-cycle pop of v and a same-cycle write to v.
  - The write is discarded silently, with no overflow.
- Sticky flags clear only on reset.
- o_en is combinational from i_en (documented timing path); consumers must not loop o_en back into i_en.

Decomposition:
- Package lib_pkg (shared library package):
  - function for clog2-based widths (VC_W, CNT_W);
  - typedef of the per-channel status struct {empty, full, almost_full, count}.
- Sub-module lib_vc_fifo_chan: one channel's storage, pointers, count, flags and flush.
  - Takes a wr_req qualified by channel decode, plus pop and flush.
  - Returns head, status and a wr_drop indication.
- Top level: channel decode, generate loop of N_VC channel instances, output packing, sticky error OR-reduction.
- RTL target: about 200 lines total.

Test Plan:
(WIDTH=4, DEPTH=4, N_VC=2, AF_THRESH=3)
1. Reset, then write D,E,A,D to VC0, no pops.
   - o_count[0] goes 1,2,3,4; o_almost_full[0] rises at 3, o_full[0] at 4.
   - o_data[0]=D from the cycle after the first write; VC1 stays empty.
2. VC0 full, write B to VC0 without pop -> dropped, o_overflow=1, contents D,E,A,D unchanged.
3. VC0 full, write B with i_en[0]=1 -> o_data[0] becomes E, count stays 4; draining then yields E,A,D,B.
4. Interleave writes 1 to VC1 and 7 to VC0 while popping VC0 each cycle -> VC1 count increments independently, o_data[1]=1; VC0 pops follow FIFO order.
5. i_en[1]=1 on empty VC1 with a same-cycle write of 5 to VC1 -> o_underflow=1, count[1]=1, o_data[1]=5.
6. VC0 holding 3 words: assert i_flush[0] with a write to VC0, then pulse reset_n low mid-stream.
   - Flush: VC0 empties, no overflow, o_data[0]=0.
   - Reset: all flags and counts return to their reset values.
